// File: rtl/gpio_cmd_master_if.sv
// Command, GPIO and response bundle for gpio_cmd_master.
// The master modport is the initiator's view; slave is the view of whatever
// sits on the far side (local command source, register file, or a bench).
interface gpio_cmd_master_if #(
    parameter int NB_GPIOS  = 32,
    parameter int NB_OPCODE = 8,
    parameter int NB_DATA   = 23
);
    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    logic [NB_OPCODE-1:0]  i_cmd_opcode;
    logic [NB_DATA-1:0]    i_cmd_data;
    logic [NB_GPIOS-1:0]   o_gpo;
    logic [NB_GPIOS-1:0]   i_gpi;
    logic                  o_rsp_valid;
    logic [NB_GPIOS-1:0]   o_rsp_data;
    logic                  o_busy;

    modport master (
        input  i_cmd_valid,
        input  i_cmd_opcode,
        input  i_cmd_data,
        input  i_gpi,
        output o_cmd_ready,
        output o_gpo,
        output o_rsp_valid,
        output o_rsp_data,
        output o_busy
    );

    modport slave (
        output i_cmd_valid,
        output i_cmd_opcode,
        output i_cmd_data,
        output i_gpi,
        input  o_cmd_ready,
        input  o_gpo,
        input  o_rsp_valid,
        input  o_rsp_data,
        input  o_busy
    );
endinterface

// File: rtl/gpio_cmd_master.sv
// GPIO command initiator: accepts one command at a time, drives
// {opcode, enable, data} on gpo with a timed enable strobe, then samples gpi
// after a settle time and returns it with a one-cycle response pulse.
module gpio_cmd_master #(
    parameter int NB_GPIOS  = 32,
    parameter int NB_OPCODE = 8,
    parameter int NB_DATA   = 23,
    parameter int ENB_BIT   = 23,
    parameter int NB_SETUP  = 2,
    parameter int NB_PULSE  = 4,
    parameter int NB_WAIT   = 4
) (
    input  logic clk,
    input  logic i_rst,
    gpio_cmd_master_if.master bus
);

    // One shared down-counter, sized for the longest phase.
    localparam int MAX_SP  = (NB_SETUP > NB_PULSE) ? NB_SETUP : NB_PULSE;
    localparam int MAX_CNT = (MAX_SP > NB_WAIT) ? MAX_SP : NB_WAIT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    // Reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(NB_SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(NB_PULSE - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(NB_WAIT - 1);

    // Field layout must tile gpo exactly with the strobe between opcode and data.
    generate
        if (NB_GPIOS != NB_OPCODE + 1 + NB_DATA) begin : g_bad_width
            $error("gpio_cmd_master: NB_GPIOS must equal NB_OPCODE+1+NB_DATA");
        end
        if (ENB_BIT != NB_DATA) begin : g_bad_enb
            $error("gpio_cmd_master: ENB_BIT must equal NB_DATA");
        end
        if (NB_SETUP < 1 || NB_PULSE < 1 || NB_WAIT < 1) begin : g_bad_timing
            $error("gpio_cmd_master: NB_SETUP, NB_PULSE and NB_WAIT must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [NB_GPIOS-1:0] gpo_reg;
    logic                rsp_valid_reg;
    logic [NB_GPIOS-1:0] rsp_data_reg;

    // Command sequencer: phase timing, gpo drive and response capture.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            gpo_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.i_cmd_valid) begin
                        // Capture the command now; later input changes are ignored.
                        gpo_reg   <= {bus.i_cmd_opcode, 1'b0, bus.i_cmd_data};
                        cnt_reg   <= SETUP_LOAD;
                        state_reg <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_reg == '0) begin
                        gpo_reg[ENB_BIT] <= 1'b1;
                        cnt_reg          <= PULSE_LOAD;
                        state_reg        <= ST_PULSE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt_reg == '0) begin
                        gpo_reg[ENB_BIT] <= 1'b0;
                        cnt_reg          <= WAIT_LOAD;
                        state_reg        <= ST_WAIT;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == '0) begin
                        rsp_data_reg  <= bus.i_gpi;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready and busy are pure decodes of the state register.
    assign bus.o_cmd_ready = (state_reg == ST_IDLE);
    assign bus.o_busy      = (state_reg != ST_IDLE);
    assign bus.o_gpo       = gpo_reg;
    assign bus.o_rsp_valid = rsp_valid_reg;
    assign bus.o_rsp_data  = rsp_data_reg;

endmodule
